// File: rtl/adder_subtractor_multiprecision_scheduler_pkg.sv
// Shared types and helpers for the multiprecision adder/subtractor scheduler.
// Holds the scheduler state encoding and a constant clog2 helper.
package adder_subtractor_multiprecision_scheduler_pkg;

    localparam int DEFAULT_REQUESTER_COUNT = 4;
    localparam int DEFAULT_WORD_WIDTH      = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_WAIT   = 2'b11,
        ST_RETURN = 2'b10
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/adder_subtractor_multiprecision_scheduler_if.sv
// Client, shared-adder and status signals of the scheduler in one bundle.
// The slave modport is the scheduler's view; master is the environment's view.
interface adder_subtractor_multiprecision_scheduler_if
    import adder_subtractor_multiprecision_scheduler_pkg::*;
#(
    parameter int REQUESTER_COUNT = DEFAULT_REQUESTER_COUNT,
    parameter int WORD_WIDTH      = DEFAULT_WORD_WIDTH,
    parameter int ID_WIDTH        = clog2(REQUESTER_COUNT)
);

    logic [REQUESTER_COUNT-1:0]            req_valid;
    logic [REQUESTER_COUNT-1:0]            req_ready;
    logic [REQUESTER_COUNT-1:0]            req_add_sub;
    logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_A;
    logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_B;

    logic [REQUESTER_COUNT-1:0]            rsp_valid;
    logic [REQUESTER_COUNT-1:0]            rsp_ready;
    logic [WORD_WIDTH-1:0]                 rsp_sum;
    logic [WORD_WIDTH-1:0]                 rsp_carries;
    logic                                  rsp_carry_out;
    logic                                  rsp_overflow;

    logic                                  adder_input_valid;
    logic                                  adder_input_ready;
    logic                                  adder_add_sub;
    logic [WORD_WIDTH-1:0]                 adder_A;
    logic [WORD_WIDTH-1:0]                 adder_B;
    logic                                  adder_output_valid;
    logic                                  adder_output_ready;
    logic [WORD_WIDTH-1:0]                 adder_sum;
    logic [WORD_WIDTH-1:0]                 adder_carries;
    logic                                  adder_carry_out;
    logic                                  adder_overflow;

    logic [ID_WIDTH-1:0]                   grant_id;
    logic                                  busy;

    modport slave (
        input  req_valid, req_add_sub, req_A, req_B, rsp_ready,
        input  adder_input_ready, adder_output_valid,
        input  adder_sum, adder_carries, adder_carry_out, adder_overflow,
        output req_ready, rsp_valid, rsp_sum, rsp_carries, rsp_carry_out, rsp_overflow,
        output adder_input_valid, adder_add_sub, adder_A, adder_B, adder_output_ready,
        output grant_id, busy
    );

    modport master (
        output req_valid, req_add_sub, req_A, req_B, rsp_ready,
        output adder_input_ready, adder_output_valid,
        output adder_sum, adder_carries, adder_carry_out, adder_overflow,
        input  req_ready, rsp_valid, rsp_sum, rsp_carries, rsp_carry_out, rsp_overflow,
        input  adder_input_valid, adder_add_sub, adder_A, adder_B, adder_output_ready,
        input  grant_id, busy
    );

endinterface

// File: rtl/adder_subtractor_multiprecision_scheduler_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// Latency: purely combinational. Backpressure: none, the caller decides when to advance the pointer.
module adder_subtractor_multiprecision_scheduler_arbiter
    import adder_subtractor_multiprecision_scheduler_pkg::*;
#(
    parameter int REQUESTER_COUNT = DEFAULT_REQUESTER_COUNT,
    parameter int ID_WIDTH        = clog2(REQUESTER_COUNT)
) (
    input  logic [REQUESTER_COUNT-1:0] requests,
    input  logic [ID_WIDTH-1:0]        pointer,
    output logic [REQUESTER_COUNT-1:0] grant,
    output logic [ID_WIDTH-1:0]        grant_idx,
    output logic                       grant_vld
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            idx = (int'(pointer) + i) % REQUESTER_COUNT;
            if (!grant_vld && requests[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_WIDTH'(idx);
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_subtractor_multiprecision_scheduler.sv
// Shares one multiprecision adder/subtractor among several clients, round-robin, one op in flight.
// Latency: accept at cycle 0, adder request from cycle 1, response 1 cycle after the adder result handshake.
// Backpressure: req_ready is low while busy; adder and client stalls hold the latched operands/result.
module adder_subtractor_multiprecision_scheduler
    import adder_subtractor_multiprecision_scheduler_pkg::*;
#(
    parameter int REQUESTER_COUNT = DEFAULT_REQUESTER_COUNT,
    parameter int WORD_WIDTH      = DEFAULT_WORD_WIDTH,
    parameter int ID_WIDTH        = clog2(REQUESTER_COUNT)
) (
    input  logic clock,
    input  logic clear_n,
    adder_subtractor_multiprecision_scheduler_if.slave bus
);

    state_t                      state_q;
    state_t                      state_d;
    logic [ID_WIDTH-1:0]         ptr_q;
    logic [ID_WIDTH-1:0]         grant_id_q;
    logic                        op_add_sub_q;
    logic [WORD_WIDTH-1:0]       op_a_q;
    logic [WORD_WIDTH-1:0]       op_b_q;
    logic [WORD_WIDTH-1:0]       res_sum_q;
    logic [WORD_WIDTH-1:0]       res_carries_q;
    logic                        res_carry_out_q;
    logic                        res_overflow_q;

    logic [REQUESTER_COUNT-1:0]  arb_grant;
    logic [ID_WIDTH-1:0]         arb_idx;
    logic                        arb_vld;
    logic                        accept;
    logic                        res_take;
    logic [ID_WIDTH-1:0]         ptr_next;

    adder_subtractor_multiprecision_scheduler_arbiter #(
        .REQUESTER_COUNT (REQUESTER_COUNT),
        .ID_WIDTH        (ID_WIDTH)
    ) u_arbiter (
        .requests  (bus.req_valid),
        .pointer   (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // req_ready is the arbiter grant in IDLE, so a valid winner is an accepted request.
    assign accept   = (state_q == ST_IDLE) && arb_vld;
    assign res_take = (state_q == ST_WAIT) && bus.adder_output_valid;
    assign ptr_next = (arb_idx == ID_WIDTH'(REQUESTER_COUNT - 1)) ? '0 : arb_idx + 1'b1;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q         <= ST_IDLE;
            ptr_q           <= '0;
            grant_id_q      <= '0;
            op_add_sub_q    <= 1'b0;
            op_a_q          <= '0;
            op_b_q          <= '0;
            res_sum_q       <= '0;
            res_carries_q   <= '0;
            res_carry_out_q <= 1'b0;
            res_overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_add_sub_q <= bus.req_add_sub[arb_idx];
                op_a_q       <= bus.req_A[arb_idx*WORD_WIDTH +: WORD_WIDTH];
                op_b_q       <= bus.req_B[arb_idx*WORD_WIDTH +: WORD_WIDTH];
                grant_id_q   <= arb_idx;
                ptr_q        <= ptr_next;
            end
            if (res_take) begin
                res_sum_q       <= bus.adder_sum;
                res_carries_q   <= bus.adder_carries;
                res_carry_out_q <= bus.adder_carry_out;
                res_overflow_q  <= bus.adder_overflow;
            end
        end
    end

    // Data outputs are gated per state so an idle block presents all zeros.
    always_comb begin
        state_d                = state_q;
        bus.req_ready          = '0;
        bus.rsp_valid          = '0;
        bus.rsp_sum            = '0;
        bus.rsp_carries        = '0;
        bus.rsp_carry_out      = 1'b0;
        bus.rsp_overflow       = 1'b0;
        bus.adder_input_valid  = 1'b0;
        bus.adder_add_sub      = 1'b0;
        bus.adder_A            = '0;
        bus.adder_B            = '0;
        bus.adder_output_ready = 1'b0;
        bus.busy               = 1'b1;
        case (state_q)
            ST_IDLE: begin
                bus.busy      = 1'b0;
                bus.req_ready = arb_grant;
                if (arb_vld) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.adder_input_valid = 1'b1;
                bus.adder_add_sub     = op_add_sub_q;
                bus.adder_A           = op_a_q;
                bus.adder_B           = op_b_q;
                if (bus.adder_input_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                bus.adder_output_ready = 1'b1;
                if (bus.adder_output_valid) state_d = ST_RETURN;
            end
            ST_RETURN: begin
                bus.rsp_valid     = {{(REQUESTER_COUNT-1){1'b0}}, 1'b1} << grant_id_q;
                bus.rsp_sum       = res_sum_q;
                bus.rsp_carries   = res_carries_q;
                bus.rsp_carry_out = res_carry_out_q;
                bus.rsp_overflow  = res_overflow_q;
                if (bus.rsp_ready[grant_id_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_adder_subtractor_multiprecision_scheduler.sv
// Directed and randomized bench for the adder/subtractor scheduler; the bench plays both clients and the adder.
module tb_adder_subtractor_multiprecision_scheduler;

    localparam int N = 4;
    localparam int W = 128;

    logic clock;
    logic clear_n;

    adder_subtractor_multiprecision_scheduler_if #(.REQUESTER_COUNT(N), .WORD_WIDTH(W)) bus ();

    adder_subtractor_multiprecision_scheduler #(.REQUESTER_COUNT(N), .WORD_WIDTH(W)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    int            rr_ptr = 0;
    logic [N-1:0]  rv;
    logic [W-1:0]  cl_a [N];
    logic [W-1:0]  cl_b [N];
    logic          cl_op [N];
    logic [W-1:0]  obs_sum;
    logic          obs_co;
    logic          obs_ov;
    int            obs_gid;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_A[i*W +: W] = cl_a[i];
            bus.req_B[i*W +: W] = cl_b[i];
            bus.req_add_sub[i]  = cl_op[i];
        end
        bus.req_valid = rv;
    endtask

    // Reference arithmetic: modular sum/difference, unsigned carry (no borrow), signed range overflow.
    task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                            output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0]          uadd;
        logic signed [W+1:0] sa, sb, sr;
        uadd = {1'b0, a} + {1'b0, b};
        s    = op ? (a - b) : (a + b);
        co   = op ? (a >= b) : uadd[W];
        sa   = $signed({{2{a[W-1]}}, a});
        sb   = $signed({{2{b[W-1]}}, b});
        sr   = op ? (sa - sb) : (sa + sb);
        ov   = !((sr[W+1:W-1] == 3'b000) || (sr[W+1:W-1] == 3'b111));
    endtask

    // One full operation; called at posedge+1 with the scheduler idle and requests driven.
    task automatic run_one(input int in_stall, input int out_lat, input int rsp_stall, input bit rearm);
        int           w;
        logic [W-1:0] one_hot, ea, eb, es, ec;
        logic         eop, eco, eov;
        w = -1;
        for (int i = 0; i < N; i++) begin
            if (w < 0 && rv[(rr_ptr + i) % N]) w = (rr_ptr + i) % N;
        end
        if (w < 0) begin
            rv[rr_ptr] = 1'b1;
            drive_reqs();
            w = rr_ptr;
        end
        one_hot = W'(1) << w;
        ea = cl_a[w]; eb = cl_b[w]; eop = cl_op[w];
        #1;
        chk("req_ready_idle", W'(bus.req_ready), one_hot);
        chk("busy_idle", W'(bus.busy), '0);
        tick();
        obs_gid = int'(bus.grant_id);
        chk("grant_id", W'(bus.grant_id), W'(w));
        chk("busy_issue", W'(bus.busy), W'(1));
        chk("adder_input_valid", W'(bus.adder_input_valid), W'(1));
        chk("adder_A", bus.adder_A, ea);
        chk("adder_B", bus.adder_B, eb);
        chk("adder_add_sub", W'(bus.adder_add_sub), W'(eop));
        chk("req_ready_busy", W'(bus.req_ready), '0);
        if (rearm) begin
            cl_a[w] = rnd(); cl_b[w] = rnd(); cl_op[w] = 1'($urandom % 2);
        end else begin
            rv[w] = 1'b0;
        end
        drive_reqs();
        for (int k = 0; k < in_stall; k++) begin
            bus.adder_output_valid = 1'($urandom % 2);
            tick();
            chk("adder_A_stable", bus.adder_A, ea);
            chk("adder_B_stable", bus.adder_B, eb);
            chk("req_ready_stall", W'(bus.req_ready), '0);
            chk("out_ready_issue", W'(bus.adder_output_ready), '0);
        end
        bus.adder_output_valid = 1'b0;
        bus.adder_input_ready  = 1'b1;
        tick();
        bus.adder_input_ready = 1'b0;
        chk("out_ready_wait", W'(bus.adder_output_ready), W'(1));
        chk("in_valid_wait", W'(bus.adder_input_valid), '0);
        for (int k = 0; k < out_lat; k++) begin
            tick();
            chk("rsp_valid_wait", W'(bus.rsp_valid), '0);
        end
        model_op(ea, eb, eop, es, eco, eov);
        ec = rnd();
        bus.adder_sum = es; bus.adder_carries = ec;
        bus.adder_carry_out = eco; bus.adder_overflow = eov;
        bus.adder_output_valid = 1'b1;
        tick();
        bus.adder_output_valid = 1'b0;
        bus.adder_sum = rnd(); bus.adder_carries = rnd();
        bus.adder_carry_out = ~eco; bus.adder_overflow = ~eov;
        obs_sum = bus.rsp_sum; obs_co = bus.rsp_carry_out; obs_ov = bus.rsp_overflow;
        chk("rsp_valid", W'(bus.rsp_valid), one_hot);
        chk("rsp_sum", bus.rsp_sum, es);
        chk("rsp_carries", bus.rsp_carries, ec);
        chk("rsp_carry_out", W'(bus.rsp_carry_out), W'(eco));
        chk("rsp_overflow", W'(bus.rsp_overflow), W'(eov));
        chk("out_ready_return", W'(bus.adder_output_ready), '0);
        for (int k = 0; k < rsp_stall; k++) begin
            bus.rsp_ready = ~one_hot[N-1:0];
            bus.adder_output_valid = 1'($urandom % 2);
            tick();
            chk("rsp_valid_hold", W'(bus.rsp_valid), one_hot);
            chk("rsp_sum_hold", bus.rsp_sum, es);
            chk("req_ready_return", W'(bus.req_ready), '0);
        end
        bus.adder_output_valid = 1'b0;
        bus.rsp_ready = one_hot[N-1:0];
        tick();
        bus.rsp_ready = '0;
        chk("rsp_valid_done", W'(bus.rsp_valid), '0);
        chk("busy_done", W'(bus.busy), '0);
        rr_ptr = (w + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rv = '0;
        for (int i = 0; i < N; i++) begin
            cl_a[i] = '0; cl_b[i] = '0; cl_op[i] = 1'b0;
        end
        bus.rsp_ready = '0;
        bus.adder_input_ready = 1'b0;
        bus.adder_output_valid = 1'b0;
        bus.adder_sum = '0; bus.adder_carries = '0;
        bus.adder_carry_out = 1'b0; bus.adder_overflow = 1'b0;
        drive_reqs();
        clear_n = 1'b1;
        #1 clear_n = 1'b0;
        #2;
        chk("rst_busy", W'(bus.busy), '0);
        chk("rst_grant_id", W'(bus.grant_id), '0);
        chk("rst_in_valid", W'(bus.adder_input_valid), '0);
        chk("rst_out_ready", W'(bus.adder_output_ready), '0);
        chk("rst_rsp_valid", W'(bus.rsp_valid), '0);
        chk("rst_req_ready", W'(bus.req_ready), '0);
        chk("rst_rsp_sum", bus.rsp_sum, '0);
        chk("rst_adder_A", bus.adder_A, '0);
        #9 clear_n = 1'b1;
        tick();

        // Fairness: every client requests continuously.
        rv = '1;
        for (int i = 0; i < N; i++) begin
            cl_a[i] = rnd(); cl_b[i] = rnd(); cl_op[i] = 1'($urandom % 2);
        end
        drive_reqs();
        for (int k = 0; k < 8; k++) begin
            run_one($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
            chk("fair_seq", W'(obs_gid), W'(k % N));
        end
        rv = '0;
        drive_reqs();

        // Single add from client 2.
        cl_a[2] = 128'd5; cl_b[2] = 128'd3; cl_op[2] = 1'b0; rv = 4'b0100;
        drive_reqs();
        run_one(0, 1, 0, 1'b0);
        chk("t1_sum", obs_sum, 128'd8);
        chk("t1_carry_out", W'(obs_co), '0);

        // Subtract overflow from client 0.
        cl_a[0] = {1'b0, {127{1'b1}}}; cl_b[0] = '1; cl_op[0] = 1'b1; rv = 4'b0001;
        drive_reqs();
        run_one(1, 0, 1, 1'b0);
        chk("t2_sum", obs_sum, {1'b1, 127'd0});
        chk("t2_overflow", W'(obs_ov), W'(1));

        // Long backpressure on both sides, client 1.
        cl_a[1] = rnd(); cl_b[1] = rnd(); cl_op[1] = 1'b0; rv = 4'b0010;
        drive_reqs();
        run_one(10, 2, 5, 1'b0);

        // Reset while waiting for the adder; pointer was at 2 before reset.
        cl_a[1] = rnd(); rv = 4'b0010;
        drive_reqs();
        tick();
        chk("t5_grant", W'(bus.grant_id), W'(1));
        rv = '0;
        drive_reqs();
        bus.adder_input_ready = 1'b1;
        tick();
        bus.adder_input_ready = 1'b0;
        chk("t5_in_wait", W'(bus.adder_output_ready), W'(1));
        #2 clear_n = 1'b0;
        #1;
        chk("t5_busy", W'(bus.busy), '0);
        chk("t5_out_ready", W'(bus.adder_output_ready), '0);
        chk("t5_rsp_valid", W'(bus.rsp_valid), '0);
        rr_ptr = 0;
        @(posedge clock);
        #1 clear_n = 1'b1;
        cl_a[0] = rnd(); cl_b[0] = rnd(); cl_a[2] = rnd(); cl_b[2] = rnd();
        rv = 4'b0101;
        drive_reqs();
        run_one(0, 0, 0, 1'b0);
        chk("t5_first_after_rst", W'(obs_gid), '0);
        run_one(0, 0, 0, 1'b0);
        chk("t5_waiting_client", W'(obs_gid), W'(2));

        // Stray adder result while idle.
        bus.adder_output_valid = 1'b1;
        bus.adder_sum = rnd();
        #1;
        chk("t6_out_ready", W'(bus.adder_output_ready), '0);
        chk("t6_rsp_valid", W'(bus.rsp_valid), '0);
        tick();
        bus.adder_output_valid = 1'b0;
        tick();
        chk("t6_rsp_valid_after", W'(bus.rsp_valid), '0);
        chk("t6_busy", W'(bus.busy), '0);

        // Randomized traffic; pending clients sometimes withdraw before being granted.
        for (int it = 0; it < 24; it++) begin
            rv = rv | 4'($urandom);
            rv = rv & ~4'($urandom % 3 == 0 ? $urandom : 0);
            for (int i = 0; i < N; i++) begin
                cl_a[i] = ($urandom % 4 == 0) ? '1 : rnd();
                cl_b[i] = rnd();
                cl_op[i] = 1'($urandom % 2);
            end
            drive_reqs();
            run_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom % 2));
        end
        rv = '0;
        drive_reqs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_subtractor_multiprecision_scheduler.md
Name: adder_subtractor_multiprecision_scheduler

Overview:
Shares one multiprecision adder/subtractor (128-bit, 16-bit steps, valid/ready on both sides) among REQUESTER_COUNT clients. Uses round-robin arbitration. Captures the winner's operands and issues them to the adder. Waits for the result, then returns sum, carry_out, carries and overflow to the winner only. One operation is in flight at a time.

Parameters:
REQUESTER_COUNT, 4, number of client ports; must be at least 2.
WORD_WIDTH, 128, operand and result width; must match the shared adder.
ID_WIDTH, clog2(REQUESTER_COUNT), width of the requester index.

Ports:
clock  in  1  single clock; all logic is rising-edge.
clear_n  in  1  asynchronous, active-low reset.
req_valid  in  REQUESTER_COUNT  per-client request valid.
req_ready  out  REQUESTER_COUNT  per-client request ready; at most one bit high.
req_add_sub  in  REQUESTER_COUNT  per-client operation: 0 = A+B, 1 = A-B.
req_A  in  REQUESTER_COUNT*WORD_WIDTH  packed operand A; client i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
req_B  in  REQUESTER_COUNT*WORD_WIDTH  packed operand B; same packing as req_A.
rsp_valid  out  REQUESTER_COUNT  per-client response valid; at most one bit high.
rsp_ready  in  REQUESTER_COUNT  per-client response ready.
rsp_sum  out  WORD_WIDTH  result sum, broadcast to all clients.
rsp_carries  out  WORD_WIDTH  result carries, broadcast.
rsp_carry_out  out  1  result carry_out, broadcast.
rsp_overflow  out  1  result overflow, broadcast.
adder_input_valid  out  1  request valid to the shared adder.
adder_input_ready  in  1  shared adder ready to accept.
adder_add_sub  out  1  operation to the adder.
adder_A  out  WORD_WIDTH  operand A to the adder.
adder_B  out  WORD_WIDTH  operand B to the adder.
adder_output_valid  in  1  adder result valid.
adder_output_ready  out  1  ready to take the adder result.
adder_sum  in  WORD_WIDTH  adder sum.
adder_carries  in  WORD_WIDTH  adder carries.
adder_carry_out  in  1  adder carry_out.
adder_overflow  in  1  adder overflow.
grant_id  out  ID_WIDTH  index of the current or last winner.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state = IDLE; priority pointer = 0; grant_id = 0.
  - All operand and result registers = 0.
  - All handshake outputs = 0, except req_ready, which follows the IDLE rule below.
- States:
  - IDLE:
    - Combinational round-robin pick over req_valid, starting at the priority pointer.
    - req_ready = one-hot of the winner, all zeros if no request.
    - On req_valid[w] && req_ready[w]: latch add_sub, A and B of client w; grant_id <= w; pointer <= (w+1) mod REQUESTER_COUNT; go to ISSUE.
  - ISSUE:
    - adder_input_valid = 1, with the latched operands on adder_add_sub, adder_A and adder_B.
    - On adder_input_ready: go to WAIT.
  - WAIT:
    - adder_output_ready = 1.
    - On adder_output_valid: latch sum, carries, carry_out and overflow; go to RETURN.
  - RETURN:
    - rsp_valid[grant_id] = 1; rsp_* drive the latched result.
    - On rsp_ready[grant_id]: go to IDLE.
    - rsp_ready of non-granted clients is ignored.
- Handshake rules:
  - All handshakes are valid && ready in the same cycle.
  - Outputs in each state are pure decodes of the registered state.
  - Latched operands are stable through ISSUE.
  - The latched result is stable through RETURN.
- Latency:
  - Request accept at cycle 0.
  - adder_input_valid high from cycle 1.
  - rsp_valid high 1 cycle after the adder output handshake.
  - Minimum request-to-request spacing per port is 4 cycles plus the adder compute time.
- Round-robin and ordering:
  - The priority pointer advances only on a grant.
  - A client that lowers req_valid before it is granted loses nothing.
  - Under sustained requests from all clients, grants are strictly 0,1,2,3,0,...
- Boundary conditions:
  - adder_output_valid seen in IDLE, ISSUE or RETURN: adder_output_ready is 0 there, so it is ignored.
  - Reset mid-operation: the scheduler returns to IDLE immediately. The integrator must reset the adder in the same cycle; there is no recovery from a stale adder result.
  - No client requesting: the block stays in IDLE with all outputs 0.

Decomposition:
- Shared header: state encodings (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b11, RETURN=2'b10) and the existing clog2 function include.
- Sub-module arbiter_round_robin (parameter REQUESTER_COUNT):
  - Inputs: requests, priority pointer.
  - Output: one-hot grant plus encoded index.
  - Purely combinational.
- Operand and result registers, and the pointer, use the existing Register module.

Test Plan:
1. Single request: client 2 requests A=5, B=3, add_sub=0.
   - Required: req_ready=4'b0100 in the same cycle; adder_A=5 and adder_B=3 the next cycle.
   - Required: rsp_valid=4'b0100 with rsp_sum=8 and rsp_carry_out=0; no other rsp_valid bit ever set.
2. Subtract overflow: client 0 requests A=2^127-1, B=-1 (all ones), add_sub=1.
   - Required: rsp_sum=2^127 (0x8000…0), rsp_overflow=1.
3. Fairness: all four clients hold req_valid=1 for 8 operations.
   - Required: grant_id sequence 0,1,2,3,0,1,2,3.
4. Backpressure: hold adder_input_ready=0 for 10 cycles, then hold rsp_ready=0 for 5 cycles.
   - Required: adder_A/B and rsp_sum remain stable; req_ready stays 4'b0000 until the response handshake.
5. Reset mid-operation: assert clear_n=0 while in WAIT.
   - Required: busy=0, adder_output_ready=0 and rsp_valid=0 asynchronously; the next grant after release goes to client 0.
6. Stray result: pulse adder_output_valid in IDLE.
   - Required: adder_output_ready=0; no rsp_valid asserted.
